vector_mem_sequencer: RTL

//  Memory-stage sequencer between the Execute->Memory pipeline register and a single-port, byte-wide data RAM.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/vector_mem_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared types and sizing for the memory-stage sequencer: FSM state encoding
// and default lane geometry.
package cpu_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_VECTOR_SIZE = 6;
  localparam int VECTOR_BITS         = DEFAULT_DATA_WIDTH * DEFAULT_VECTOR_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DRAIN,
    DONE
  } memseq_state_t;

endpackage

// File: rtl/vector_mem_sequencer.sv
// Memory-stage sequencer: turns one vector/scalar load or store into byte beats
// on a single-port byte-wide RAM with one-cycle synchronous read latency.
module vector_mem_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int VECTOR_SIZE = DEFAULT_VECTOR_SIZE,
  parameter int BEAT_WIDTH  = $clog2(VECTOR_SIZE) + 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              reqValid,
  input  logic                              reqWrite,
  input  logic                              reqScalar,
  input  logic [DATA_WIDTH-1:0]             reqAddress,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] reqWriteData,
  output logic                              busy,
  output logic                              done,
  output logic [DATA_WIDTH*VECTOR_SIZE-1:0] readData,
  output logic [DATA_WIDTH-1:0]             ramAddress,
  output logic                              ramWriteEnable,
  output logic [DATA_WIDTH-1:0]             ramWriteData,
  input  logic [DATA_WIDTH-1:0]             ramReadData
);

  localparam int                    VEC_W         = DATA_WIDTH * VECTOR_SIZE;
  localparam logic [BEAT_WIDTH-1:0] LAST_VEC_BEAT = BEAT_WIDTH'(VECTOR_SIZE - 1);

  memseq_state_t         state_q;
  logic [BEAT_WIDTH-1:0] beat_q;
  logic                  write_q;
  logic                  scalar_q;
  logic [VEC_W-1:0]      wdata_q;
  logic [VEC_W-1:0]      read_data_q;
  logic [VEC_W-1:0]      read_data_d;
  logic [DATA_WIDTH-1:0] ram_address_q;
  logic                  ram_we_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  last_beat;
  logic [BEAT_WIDTH-1:0] next_beat;
  logic [DATA_WIDTH-1:0] next_lane_data;
  logic                  capture_en;
  logic [BEAT_WIDTH-1:0] capture_lane;

  assign last_beat = scalar_q ? (beat_q == '0) : (beat_q == LAST_VEC_BEAT);
  assign next_beat = beat_q + 1'b1;

  // Read data lags its address by one cycle, so beat i lands the byte of beat i-1.
  assign capture_en   = !write_q && ((state_q == BEAT && beat_q != '0) || state_q == DRAIN);
  assign capture_lane = (state_q == DRAIN) ? LAST_VEC_BEAT : beat_q - 1'b1;

  // Lane-select mux feeding the next beat's store byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    next_lane_data = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      if (next_beat == BEAT_WIDTH'(i)) next_lane_data = wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Lane-write demux into the load result; a scalar load clears the upper lanes.
  always_comb begin
    read_data_d = read_data_q;
    if (state_q == DRAIN && scalar_q) begin
      read_data_d = {{(VEC_W - DATA_WIDTH){1'b0}}, ramReadData};
    end else if (capture_en) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        if (capture_lane == BEAT_WIDTH'(i)) read_data_d[i*DATA_WIDTH +: DATA_WIDTH] = ramReadData;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: all state, including latched request fields and readData, is reset and
    // updated with non-blocking assignments, so outputs are never X and
    // ramWriteEnable drops the instant reset rises.
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      write_q       <= 1'b0;
      scalar_q      <= 1'b0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      ram_address_q <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            write_q       <= reqWrite;
            scalar_q      <= reqScalar;
            wdata_q       <= reqWriteData;
            beat_q        <= '0;
            ram_address_q <= reqAddress;
            ram_we_q      <= reqWrite;
            ram_wdata_q   <= reqWrite ? reqWriteData[DATA_WIDTH-1:0] : '0;
            busy_q        <= 1'b1;
            state_q       <= BEAT;
          end else begin
            ram_address_q <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
          end
        end
        BEAT: begin
          if (last_beat) begin
            ram_address_q <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            if (write_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            beat_q        <= next_beat;
            ram_address_q <= ram_address_q + 1'b1;
            ram_wdata_q   <= write_q ? next_lane_data : '0;
          end
        end
        DRAIN: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign readData       = read_data_q;
  assign ramAddress     = ram_address_q;
  assign ramWriteEnable = ram_we_q;
  assign ramWriteData   = ram_wdata_q;

endmodule
